iommu_hpm_evt_arb: RTL and testbench
====================================

Name: iommu_hpm_evt_arb

Overview:
- Collects HPM event records from N_REQ independent translation engines.
- Buffers each engine's records in a small per-requester FIFO.
- Issues at most one record per cycle, chosen round-robin, as single-cycle event pulses plus ID fields.
- Drives the event and ID-filter inputs of iommu_hpm, so that one counter bank is shared by all engines without losing simultaneous events.

Parameters:
- N_REQ, 2, number of requesting translation engines (1..8).
- FIFO_DEPTH, 4, entries per requester FIFO (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- hpm_en_i  in  1  0 = HPM disabled (no counters or all inhibited): flush and discard
- req_valid_i  in  N_REQ  record valid per requester
- req_ready_o  out  N_REQ  record accepted when valid & ready
- req_evt_i  in  N_REQ x 6  event vector: [0] UT_REQ, [1] IOTLB_MISS, [2] DDTW, [3] PDTW, [4] S1_PTW, [5] S2_PTW
- req_did_i  in  N_REQ x 24  device_id
- req_pid_i  in  N_REQ x 20  process_id
- req_pid_v_i  in  N_REQ  process_id valid
- req_pscid_i  in  N_REQ x 20  PSCID
- req_gscid_i  in  N_REQ x 16  GSCID
- tr_request_o, iotlb_miss_o, ddt_walk_o, pdt_walk_o, s1_ptw_o, s2_ptw_o  out  1 each  event pulses to iommu_hpm
- did_o  out  24;  pid_o  out  20;  pid_v_o  out  1;  pscid_o  out  20;  gscid_o  out  16  IDs of the issued record
- drop_clr_i  in  1  synchronous clear of drop_cnt_o
- drop_cnt_o  out  16  saturating count of records discarded while disabled
- busy_o  out  1  any FIFO non-empty or output stage valid

Behaviour:
- Reset: all FIFOs empty, RR pointer = N_REQ-1 (requester 0 wins first), all outputs 0, drop_cnt_o = 0.
- Acceptance: req_ready_o[i] = ~full[i] when hpm_en_i=1; = 1 when hpm_en_i=0.
  - Ready is not raised by a same-cycle pop; a full FIFO with a concurrent pop still presents ready=0.
- Zero event vector: accepted but not enqueued and not counted.
- Arbitration (combinational on FIFO heads):
  - Search starts at pointer+1 modulo N_REQ; the first non-empty FIFO is granted and popped.
  - Pointer updates to the granted index only on a grant.
- Output stage: registered; loaded with the popped record in the same edge as the pop.
  - Event pulses and IDs are valid for exactly one cycle. With no grant, event pulses = 0 and IDs hold their last value.
  - Minimum latency: handshake at edge N, pop at edge N+1, pulse visible in cycle after N+1 (2 edges).
- Several event bits set in one record are issued together in the same pulse; iommu_hpm counts each separately.
- Throughput: one record per cycle aggregate. A single requester streaming into an empty bank sustains 1/cycle with no bubbles.
- Disable (hpm_en_i=0):
  - All FIFOs and the output stage clear at the next edge; event pulses are 0 from the next cycle.
  - Every accepted non-zero record increments drop_cnt_o (once per requester per cycle, summed, saturating at 0xFFFF).
  - FIFO contents flushed at disable are also added to drop_cnt_o.
- Re-enable: normal operation from the next edge; the pointer is not reset.
- drop_clr_i has priority over increments in the same cycle.
- Reset mid-operation: asynchronous; returns everything to reset values immediately. Records in flight are lost and not counted.

Decomposition:
- iommu_pkg:
  - HPM_EVT_W=6 and event bit index constants (EVT_UT_REQ=0 .. EVT_S2_PTW=5).
  - hpm_evt_rec_t (evt, did, pid, pid_v, pscid, gscid).
- Sub-module iommu_hpm_evt_fifo:
  - Parameterised-depth FIFO of hpm_evt_rec_t with push, pop, flush, full, empty and occupancy outputs.
  - Instantiated N_REQ times.

Test Plan:
- Single requester 0, evt=6'b000001, did=0x00ABCD -> tr_request_o pulses one cycle, 2 edges after handshake, did_o=0x00ABCD; busy_o then drops.
- Both requesters push every cycle for 8 cycles, FIFO_DEPTH=4 -> issue order alternates 0,1,0,1; each ready drops once its FIFO is full; total 16 pulses, no loss.
- Requester 1 fills to 4 entries with valid held high, then output drains one per cycle -> ready_o[1] reasserts only in the cycle after the first pop; no record duplicated.
- evt=6'b110010 (IOTLB_MISS, S1_PTW, S2_PTW) -> iotlb_miss_o, s1_ptw_o and s2_ptw_o pulse in the same cycle; evt=0 with valid -> no pulse, no count.
- 3 records queued, hpm_en_i dropped, then 5 more pushes while disabled -> no pulses; drop_cnt_o=8; drop_clr_i -> 0; counter saturates at 0xFFFF under a long push stream.
- rst_ni asserted asynchronously while FIFOs hold records -> outputs 0 immediately; after release, requester 0 is granted first.

Source files
------------

// File: rtl/iommu_pkg.sv
// ============================================================================
// Module : iommu_pkg
// Brief  : Shared types and constants for the IOMMU HPM event path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iommu_pkg;

    localparam int HPM_EVT_W      = 6;
    localparam int EVT_UT_REQ     = 0;
    localparam int EVT_IOTLB_MISS = 1;
    localparam int EVT_DDTW       = 2;
    localparam int EVT_PDTW       = 3;
    localparam int EVT_S1_PTW     = 4;
    localparam int EVT_S2_PTW     = 5;

    localparam int DID_W   = 24;
    localparam int PID_W   = 20;
    localparam int PSCID_W = 20;
    localparam int GSCID_W = 16;

    typedef struct packed {
        logic [HPM_EVT_W-1:0] evt;
        logic [DID_W-1:0]     did;
        logic [PID_W-1:0]     pid;
        logic                 pid_v;
        logic [PSCID_W-1:0]   pscid;
        logic [GSCID_W-1:0]   gscid;
    } hpm_evt_rec_t;

endpackage

`default_nettype wire

// File: rtl/iommu_hpm_evt_fifo.sv
// ============================================================================
// Module : iommu_hpm_evt_fifo
// Brief  : Per-requester FIFO of HPM event records with flush and occupancy.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iommu_hpm_evt_fifo
    import iommu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  hpm_evt_rec_t             wdata_i,
    output hpm_evt_rec_t             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    hpm_evt_rec_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_cnt;
    logic               w_push;
    logic               w_pop;

    assign w_push = push_i & ~full_o  & ~flush_i;
    assign w_pop  = pop_i  & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

    // Storage carries no reset; validity is tracked solely by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata_i;
    end

    assign rdata_o = r_mem[r_rd_ptr];
    assign full_o  = (r_cnt == (PTR_W+1)'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign cnt_o   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/iommu_hpm_evt_arb.sv
// ============================================================================
// Module : iommu_hpm_evt_arb
// Brief  : Round-robin merge of per-engine HPM event records onto one bank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iommu_hpm_evt_arb
    import iommu_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   hpm_en_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*6-1:0]     req_evt_i,
    input  logic [N_REQ*24-1:0]    req_did_i,
    input  logic [N_REQ*20-1:0]    req_pid_i,
    input  logic [N_REQ-1:0]       req_pid_v_i,
    input  logic [N_REQ*20-1:0]    req_pscid_i,
    input  logic [N_REQ*16-1:0]    req_gscid_i,
    output logic                   tr_request_o,
    output logic                   iotlb_miss_o,
    output logic                   ddt_walk_o,
    output logic                   pdt_walk_o,
    output logic                   s1_ptw_o,
    output logic                   s2_ptw_o,
    output logic [23:0]            did_o,
    output logic [19:0]            pid_o,
    output logic                   pid_v_o,
    output logic [19:0]            pscid_o,
    output logic [15:0]            gscid_o,
    input  logic                   drop_clr_i,
    output logic [15:0]            drop_cnt_o,
    output logic                   busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    hpm_evt_rec_t       w_wrec [N_REQ];
    hpm_evt_rec_t       w_head [N_REQ];
    logic [CNT_W-1:0]   w_cnt  [N_REQ];
    logic [N_REQ-1:0]   w_push;
    logic [N_REQ-1:0]   w_pop;
    logic [N_REQ-1:0]   w_full;
    logic [N_REQ-1:0]   w_empty;
    logic [N_REQ-1:0]   w_nz;

    logic               w_found;
    logic               w_gnt_vld;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_drop_inc;
    logic [31:0]        w_drop_sum;

    hpm_evt_rec_t       r_out;
    logic [IDX_W-1:0]   r_ptr;
    logic [15:0]        r_drop_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_wrec[gi] = '{
                evt:   req_evt_i  [gi*HPM_EVT_W +: HPM_EVT_W],
                did:   req_did_i  [gi*DID_W     +: DID_W],
                pid:   req_pid_i  [gi*PID_W     +: PID_W],
                pid_v: req_pid_v_i[gi],
                pscid: req_pscid_i[gi*PSCID_W   +: PSCID_W],
                gscid: req_gscid_i[gi*GSCID_W   +: GSCID_W]
            };
            assign w_nz[gi]        = |w_wrec[gi].evt;
            // While disabled everything is sunk so engines never stall.
            assign req_ready_o[gi] = hpm_en_i ? ~w_full[gi] : 1'b1;
            assign w_push[gi]      = hpm_en_i & req_valid_i[gi] & ~w_full[gi] & w_nz[gi];

            iommu_hpm_evt_fifo #(
                .DEPTH   (FIFO_DEPTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .push_i  (w_push[gi]),
                .pop_i   (w_pop[gi]),
                .flush_i (~hpm_en_i),
                .wdata_i (w_wrec[gi]),
                .rdata_o (w_head[gi]),
                .full_o  (w_full[gi]),
                .empty_o (w_empty[gi]),
                .cnt_o   (w_cnt[gi])
            );
        end
    endgenerate

    // Round-robin search beginning one past the last granted requester.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = IDX_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && !w_empty[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    assign w_gnt_vld = w_found & hpm_en_i;
    assign w_pop     = w_gnt_vld ? (N_REQ'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out <= '0;
            r_ptr <= IDX_W'(N_REQ - 1);
        end else if (!hpm_en_i) begin
            r_out <= '0;
        end else begin
            r_out.evt <= w_gnt_vld ? w_head[w_gnt_idx].evt : '0;
            if (w_gnt_vld) begin
                r_out.did   <= w_head[w_gnt_idx].did;
                r_out.pid   <= w_head[w_gnt_idx].pid;
                r_out.pid_v <= w_head[w_gnt_idx].pid_v;
                r_out.pscid <= w_head[w_gnt_idx].pscid;
                r_out.gscid <= w_head[w_gnt_idx].gscid;
                r_ptr       <= w_gnt_idx;
            end
        end
    end

    // Discards while disabled: fresh non-zero records plus anything being flushed.
    always_comb begin
        w_drop_inc = '0;
        if (!hpm_en_i) begin
            for (int i = 0; i < N_REQ; i++) begin
                w_drop_inc = w_drop_inc + 32'(req_valid_i[i] & w_nz[i]) + 32'(w_cnt[i]);
            end
        end
    end

    assign w_drop_sum = {16'b0, r_drop_cnt} + w_drop_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
        end else if (drop_clr_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum > 32'h0000_FFFF) begin
            r_drop_cnt <= 16'hFFFF;
        end else begin
            r_drop_cnt <= w_drop_sum[15:0];
        end
    end

    assign tr_request_o = r_out.evt[EVT_UT_REQ];
    assign iotlb_miss_o = r_out.evt[EVT_IOTLB_MISS];
    assign ddt_walk_o   = r_out.evt[EVT_DDTW];
    assign pdt_walk_o   = r_out.evt[EVT_PDTW];
    assign s1_ptw_o     = r_out.evt[EVT_S1_PTW];
    assign s2_ptw_o     = r_out.evt[EVT_S2_PTW];
    assign did_o        = r_out.did;
    assign pid_o        = r_out.pid;
    assign pid_v_o      = r_out.pid_v;
    assign pscid_o      = r_out.pscid;
    assign gscid_o      = r_out.gscid;
    assign drop_cnt_o   = r_drop_cnt;
    assign busy_o       = (~&w_empty) | (|r_out.evt);

endmodule

`default_nettype wire

// File: tb/tb_iommu_hpm_evt_arb.sv
// ============================================================================
// Module : tb_iommu_hpm_evt_arb
// Brief  : Scoreboard bench for the HPM event arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iommu_hpm_evt_arb;
    import iommu_pkg::*;

    localparam int N_REQ      = 2;
    localparam int FIFO_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 hpm_en;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*6-1:0]   req_evt;
    logic [N_REQ*24-1:0]  req_did;
    logic [N_REQ*20-1:0]  req_pid;
    logic [N_REQ-1:0]     req_pid_v;
    logic [N_REQ*20-1:0]  req_pscid;
    logic [N_REQ*16-1:0]  req_gscid;
    logic tr_request, iotlb_miss, ddt_walk, pdt_walk, s1_ptw, s2_ptw;
    logic [23:0]          did;
    logic [19:0]          pid;
    logic                 pid_v;
    logic [19:0]          pscid;
    logic [15:0]          gscid;
    logic                 drop_clr;
    logic [15:0]          drop_cnt;
    logic                 busy;
    logic [5:0]           ev_bus;

    assign ev_bus = {s2_ptw, s1_ptw, pdt_walk, ddt_walk, iotlb_miss, tr_request};

    always #5 clk = ~clk;

    iommu_hpm_evt_arb #(.N_REQ(N_REQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .hpm_en_i(hpm_en),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_evt_i(req_evt), .req_did_i(req_did), .req_pid_i(req_pid),
        .req_pid_v_i(req_pid_v), .req_pscid_i(req_pscid), .req_gscid_i(req_gscid),
        .tr_request_o(tr_request), .iotlb_miss_o(iotlb_miss), .ddt_walk_o(ddt_walk),
        .pdt_walk_o(pdt_walk), .s1_ptw_o(s1_ptw), .s2_ptw_o(s2_ptw),
        .did_o(did), .pid_o(pid), .pid_v_o(pid_v), .pscid_o(pscid), .gscid_o(gscid),
        .drop_clr_i(drop_clr), .drop_cnt_o(drop_cnt), .busy_o(busy)
    );

    hpm_evt_rec_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic hpm_evt_rec_t mk(input int r, input int k, input logic [5:0] e);
        hpm_evt_rec_t x;
        x.evt   = e;
        x.did   = {4'(r + 1), 20'(k)};
        x.pid   = {4'(r + 3), 16'(k)};
        x.pid_v = 1'((k + r) & 1);
        x.pscid = {4'(r + 5), 16'(k * 3)};
        x.gscid = {4'(r + 7), 12'(k)};
        return x;
    endfunction

    task automatic drive(input int r, input hpm_evt_rec_t x);
        req_evt  [r*6  +: 6]  = x.evt;
        req_did  [r*24 +: 24] = x.did;
        req_pid  [r*20 +: 20] = x.pid;
        req_pid_v[r]          = x.pid_v;
        req_pscid[r*20 +: 20] = x.pscid;
        req_gscid[r*16 +: 16] = x.gscid;
        req_valid[r]          = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every non-zero event pulse must match the head of the scoreboard.
    hpm_evt_rec_t mon_got;
    hpm_evt_rec_t mon_exp;
    always @(negedge clk) begin
        if (rst_n && ev_bus != 6'd0) begin
            mon_got = '{evt: ev_bus, did: did, pid: pid, pid_v: pid_v, pscid: pscid, gscid: gscid};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected: got %h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL pulse_rec: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    int rdy0_t [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
    int rdy1_t [10] = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1};

    initial begin
        hpm_evt_rec_t r, ra, rb;
        int a0, a1;
        logic acc0, acc1;

        rst_n = 1'b0; hpm_en = 1'b1; drop_clr = 1'b0;
        req_valid = '0; req_evt = '0; req_did = '0; req_pid = '0;
        req_pid_v = '0; req_pscid = '0; req_gscid = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_evt",   32'(ev_bus),   0);
        check("rst_did",   32'(did),      0);
        check("rst_drop",  32'(drop_cnt), 0);
        check("rst_busy",  32'(busy),     0);
        rst_n = 1'b1;
        check("rst_ready", 32'(req_ready), 32'h3);

        // Single record latency
        r = mk(0, 0, 6'b000001);
        r.did = 24'h00ABCD;
        drive(0, r);
        exp_q.push_back(r);
        tick;
        req_valid = '0;
        check("t1_no_early_pulse", 32'(tr_request), 0);
        tick;
        check("t1_pulse", 32'(tr_request), 1);
        check("t1_did",   32'(did), 32'h00ABCD);
        check("t1_busy",  32'(busy), 1);
        tick;
        check("t1_pulse_end", 32'(tr_request), 0);
        check("t1_idle",      32'(busy), 0);

        // Both requesters streaming: strict 0,1 alternation
        do_reset;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(0, k, 6'(((k + 0) % 6) + 1)));
            exp_q.push_back(mk(1, k, 6'(((k + 1) % 6) + 1)));
        end
        a0 = 0; a1 = 0;
        for (int c = 0; c < 40 && (a0 < 8 || a1 < 8); c++) begin
            if (a0 < 8) drive(0, mk(0, a0, 6'(((a0 + 0) % 6) + 1))); else req_valid[0] = 1'b0;
            if (a1 < 8) drive(1, mk(1, a1, 6'(((a1 + 1) % 6) + 1))); else req_valid[1] = 1'b0;
            if (c < 10) begin
                check($sformatf("t2_ready0_c%0d", c + 1), 32'(req_ready[0]), 32'(rdy0_t[c]));
                check($sformatf("t2_ready1_c%0d", c + 1), 32'(req_ready[1]), 32'(rdy1_t[c]));
            end
            acc0 = req_valid[0] & req_ready[0];
            acc1 = req_valid[1] & req_ready[1];
            tick;
            if (acc0) a0++;
            if (acc1) a1++;
        end
        req_valid = '0;
        check("t2_accepted", 32'(a0 + a1), 16);
        repeat (12) tick;
        check("t2_drained", 32'(exp_q.size()), 0);
        check("t2_idle",    32'(busy), 0);

        // Multi-bit event record, then zero-event record
        r = mk(0, 20, 6'b110010);
        drive(0, r);
        exp_q.push_back(r);
        tick;
        req_valid = '0;
        tick;
        check("t4_multi_bus", 32'(ev_bus), 32'h32);
        check("t4_iotlb", 32'(iotlb_miss), 1);
        check("t4_s1",    32'(s1_ptw), 1);
        check("t4_s2",    32'(s2_ptw), 1);
        tick;
        drive(1, mk(1, 21, 6'b000000));
        check("t4_zero_ready", 32'(req_ready[1]), 1);
        tick;
        req_valid = '0;
        check("t4_zero_busy", 32'(busy), 0);
        tick;
        check("t4_zero_nopulse", 32'(ev_bus), 0);
        check("t4_zero_nodrop",  32'(drop_cnt), 0);

        // Disable with 3 queued, then 5 disabled pushes
        do_reset;
        ra = mk(0, 30, 6'b000001);
        rb = mk(1, 30, 6'b000010);
        drive(0, ra); drive(1, rb);
        exp_q.push_back(ra);
        tick;
        drive(0, mk(0, 31, 6'b000100));
        drive(1, mk(1, 31, 6'b001000));
        tick;
        req_valid = '0;
        hpm_en = 1'b0;
        check("t5_ready_dis", 32'(req_ready), 32'h3);
        tick;
        check("t5_flush_drop", 32'(drop_cnt), 3);
        check("t5_no_pulse",   32'(ev_bus), 0);
        check("t5_flush_busy", 32'(busy), 0);
        drive(0, mk(0, 40, 6'b000001));
        drive(1, mk(1, 40, 6'b000010));
        tick;
        tick;
        req_valid[1] = 1'b0;
        tick;
        req_valid = '0;
        check("t5_drop8",     32'(drop_cnt), 8);
        check("t5_dis_quiet", 32'(ev_bus), 0);
        drop_clr = 1'b1;
        tick;
        drop_clr = 1'b0;
        check("t5_clr", 32'(drop_cnt), 0);
        drive(0, mk(0, 41, 6'b000001));
        drive(1, mk(1, 41, 6'b000010));
        drop_clr = 1'b1;
        tick;
        drop_clr = 1'b0;
        check("t5_clr_priority", 32'(drop_cnt), 0);
        repeat (32767) tick;
        check("t5_near_sat", 32'(drop_cnt), 32'hFFFE);
        tick;
        check("t5_sat", 32'(drop_cnt), 32'hFFFF);
        tick;
        check("t5_sat_hold", 32'(drop_cnt), 32'hFFFF);
        req_valid = '0;
        hpm_en = 1'b1;
        tick;
        check("t5_reen_idle", 32'(busy), 0);

        // Asynchronous reset with records in flight
        drive(0, mk(0, 50, 6'b000001));
        drive(1, mk(1, 50, 6'b000010));
        tick;
        drive(0, mk(0, 51, 6'b000100));
        drive(1, mk(1, 51, 6'b001000));
        tick;
        req_valid = '0;
        check("t6_busy_pre", 32'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_evt",  32'(ev_bus), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_did",  32'(did), 0);
        check("t6_rst_drop", 32'(drop_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        ra = mk(0, 60, 6'b010000);
        rb = mk(1, 60, 6'b100000);
        drive(0, ra); drive(1, rb);
        exp_q.push_back(ra);
        exp_q.push_back(rb);
        tick;
        req_valid = '0;
        tick;
        check("t6_first_r0", 32'(did), 32'(ra.did));
        tick;
        check("t6_second_r1", 32'(did), 32'(rb.did));
        repeat (3) tick;
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
